// File: rtl/bm_dag_log_pkg.sv
// Shared encodings for the bm_dag2_log_pipe slice: third-term mode select and the
// accumulator FSM states.
package bm_dag_log_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO = 2'b00,
        MODE_OR   = 2'b01,
        MODE_NOTA = 2'b10,
        MODE_NAND = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/bm_dag_log_stage.sv
// Stage 1 of the log pipe: s = (a&b) | (a^b) | t3, t3 chosen by mode, registered
// together with its valid bit.
module bm_dag_log_stage
    import bm_dag_log_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_valid,
    input  logic [1:0]      i_mode,
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    output logic [BITS-1:0] o_s,
    output logic            o_valid
);

    logic [BITS-1:0] w_t3;
    logic [BITS-1:0] w_s;
    logic [BITS-1:0] r_s;
    logic            r_valid;

    always_comb begin
        w_t3 = '0;
        case (mode_e'(i_mode))
            MODE_ZERO: w_t3 = i_b ^ i_b;
            MODE_OR:   w_t3 = i_a | i_b;
            MODE_NOTA: w_t3 = ~i_a;
            MODE_NAND: w_t3 = ~(i_a & i_b);
        endcase
    end

    assign w_s = (i_a & i_b) | (i_a ^ i_b) | w_t3;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) r_s <= w_s;
        end
    end

    assign o_s     = r_s;
    assign o_valid = r_valid;

endmodule

// File: rtl/bm_dag2_log_pipe.sv
// OR-accumulates stage-1 results over WINDOW samples (or until flush) and emits a
// registered result pulse. Define BM_DAG_LOG_PARITY_EN to add a registered parity output.
module bm_dag2_log_pipe
    import bm_dag_log_pkg::*;
#(
    parameter int BITS   = 8,
    parameter int WINDOW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      mode,
    input  logic [BITS-1:0] a_in,
    input  logic [BITS-1:0] b_in,
    input  logic            flush,
    output logic [BITS-1:0] out,
    output logic            out_valid,
    output logic            busy
`ifdef BM_DAG_LOG_PARITY_EN
    ,
    output logic            parity
`endif
);

    localparam int            CW    = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

    state_e          r_state;
    state_e          w_nstate;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [BITS-1:0] r_acc;
    logic [BITS-1:0] w_acc_nxt;
    logic [BITS-1:0] r_out;
    logic            r_out_valid;
    logic            r_busy;
    logic            w_emit;
    logic [BITS-1:0] w_s;
    logic            w_s1_valid;

    bm_dag_log_stage #(.BITS(BITS)) u_stage (
        .clock   (clock),
        .reset   (reset),
        .i_valid (in_valid),
        .i_mode  (mode),
        .i_a     (a_in),
        .i_b     (b_in),
        .o_s     (w_s),
        .o_valid (w_s1_valid)
    );

    // w_acc_nxt is the final accumulator value, so an emit always includes a
    // sample absorbed in the same cycle.
    always_comb begin
        w_nstate  = r_state;
        w_cnt_nxt = r_cnt;
        w_acc_nxt = r_acc;
        w_emit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s1_valid) begin
                    w_acc_nxt = w_s;
                    if (WINDOW == 1 || flush) begin
                        w_emit    = 1'b1;
                        w_cnt_nxt = '0;
                    end else begin
                        w_cnt_nxt = CW'(1);
                        w_nstate  = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (w_s1_valid) begin
                    w_acc_nxt = r_acc | w_s;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_cnt_nxt == WIN_C || flush) begin
                    w_emit    = 1'b1;
                    w_cnt_nxt = '0;
                    w_nstate  = IDLE;
                end
            end
        endcase
    end

    // busy stays up through the pulse cycle of a window closed from ACCUM.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_out_valid <= w_emit;
            r_busy      <= (w_nstate == ACCUM) || (w_emit && r_state == ACCUM);
            if (w_emit) r_out <= w_acc_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

`ifdef BM_DAG_LOG_PARITY_EN
    logic r_parity;

    always_ff @(posedge clock) begin
        if (reset)       r_parity <= 1'b0;
        else if (w_emit) r_parity <= ^w_acc_nxt;
    end

    assign parity = r_parity;
`endif

endmodule

// File: tb/tb_bm_dag2_log_pipe.sv
// Scoreboard bench for bm_dag2_log_pipe (BITS=8, WINDOW=4): directed windows push
// expected results, a forked monitor pops and compares on every out_valid.
module tb_bm_dag2_log_pipe;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [1:0] mode;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       flush;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;
`ifdef BM_DAG_LOG_PARITY_EN
    logic       parity;
`endif

    int         n_tests;
    int         n_fail;
    int         cyc;
    logic [7:0] exp_q[$];
    int         pulse_cyc[$];

    bm_dag2_log_pipe #(.BITS(8), .WINDOW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .mode      (mode),
        .a_in      (a_in),
        .b_in      (b_in),
        .flush     (flush),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
`ifdef BM_DAG_LOG_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got out=%0h with no result expected", out);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_out", {24'd0, out}, {24'd0, e});
`ifdef BM_DAG_LOG_PARITY_EN
                    chk("sb_parity", {31'd0, parity}, {31'd0, ^e});
`endif
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [7:0] a,
                        input logic [7:0] b, input logic f);
        in_valid = v;
        mode     = m;
        a_in     = a;
        b_in     = b;
        flush    = f;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic window4(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] want);
        exp_q.push_back(want);
        for (int i = 0; i < 4; i++) step(1'b1, m, a, b, 1'b0);
    endtask

    initial begin
        int t0;
        int np;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        mode     = 2'b00;
        a_in     = 8'h00;
        b_in     = 8'h00;
        flush    = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out", {24'd0, out}, 32'h00);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef BM_DAG_LOG_PARITY_EN
        chk("rst_parity", {31'd0, parity}, 32'd0);
`endif
        reset = 1'b0;
        idle(2);

        // full window with cycle-exact busy / out_valid
        exp_q.push_back(8'hFC);
        t0 = cyc;
        np = pulse_cyc.size();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("win_busy_c%0d", c), {31'd0, busy}, {31'd0, (c >= 2 && c <= 5)});
            chk($sformatf("win_ov_c%0d", c), {31'd0, out_valid}, {31'd0, (c == 5)});
            step(c < 4, 2'b00, 8'hF0, 8'h3C, 1'b0);
        end
        chk("win_pulses", pulse_cyc.size() - np, 32'd1);
        if (pulse_cyc.size() > np) chk("win_pulse_cycle", pulse_cyc[$] - t0, 32'd5);

        // mode coverage
        window4(2'b10, 8'h0F, 8'h00, 8'hFF);
        idle(3);
        window4(2'b11, 8'hFF, 8'hFF, 8'hFF);
        idle(3);
        window4(2'b00, 8'h00, 8'h00, 8'h00);
        idle(3);
        window4(2'b01, 8'h12, 8'h40, 8'h52);
        idle(3);

        // OR accumulation across differing samples
        exp_q.push_back(8'h0F);
        step(1'b1, 2'b00, 8'h01, 8'h00, 1'b0);
        step(1'b1, 2'b00, 8'h00, 8'h02, 1'b0);
        step(1'b1, 2'b00, 8'h04, 8'h04, 1'b0);
        step(1'b1, 2'b00, 8'h08, 8'h00, 1'b0);
        idle(4);

        // flush of a partial window, then flush in IDLE is ignored
        np = pulse_cyc.size();
        exp_q.push_back(8'h81);
        step(1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
        step(1'b1, 2'b00, 8'h80, 8'h00, 1'b0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        idle(3);
        chk("flush_busy_after", {31'd0, busy}, 32'd0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        idle(3);
        chk("flush_pulses", pulse_cyc.size() - np, 32'd1);

        // flush alongside the opening sample emits it at once
        exp_q.push_back(8'h80);
        step(1'b1, 2'b00, 8'h80, 8'h00, 1'b0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        idle(3);

        // flush in ACCUM with a concurrent sample includes that sample
        exp_q.push_back(8'h0C);
        step(1'b1, 2'b00, 8'h04, 8'h00, 1'b0);
        step(1'b1, 2'b00, 8'h08, 8'h00, 1'b0);
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        idle(4);

        // reset mid-window discards the partial result
        np = pulse_cyc.size();
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 8'h40, 8'h00, 1'b0);
        reset = 1'b1;
        step(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out", {24'd0, out}, 32'h00);
        window4(2'b00, 8'h02, 8'h00, 8'h02);
        idle(4);
        chk("midrst_pulses", pulse_cyc.size() - np, 32'd1);

        // continuous input: one emit every WINDOW cycles, no lost samples
        np = pulse_cyc.size();
        window4(2'b00, 8'h11, 8'h00, 8'h11);
        window4(2'b00, 8'h22, 8'h00, 8'h22);
        idle(6);
        chk("cont_pulses", pulse_cyc.size() - np, 32'd2);
        if (pulse_cyc.size() >= np + 2)
            chk("cont_spacing", pulse_cyc[np+1] - pulse_cyc[np], 32'd4);

        idle(4);
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
